l1_mem_bus_arbiter: RTL

- Parametrised shared-memory front end for N_PORTS L1 caches (I and D caches, multiple cores).
- Takes line-granular read/write requests from each cache's cache2mem interface and serialises them onto one main-memory port using round-robin arbitration.
- Returns line data and ready to the requester.
- Broadcasts a one-cycle snoop (address and write flag) for every granted write, so the other caches invalidate stale copies.

---
 rtl/mem_bus_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 27 ++
 rtl/l1_mem_bus_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the L1 memory bus arbiter.
package mem_bus_pkg;

  localparam int unsigned DEFAULT_WORDSIZE     = 32;
  localparam int unsigned DEFAULT_WORDSPERLINE = 2;

  typedef logic [DEFAULT_WORDSPERLINE-1:0][DEFAULT_WORDSIZE-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } bus_state_t;

  // Clear the byte-offset-within-line bits of an address.
  function automatic logic [63:0] line_align(input logic [63:0] addr,
                                             input int unsigned off_bits);
    logic [63:0] mask;
    mask = (64'd1 << off_bits) - 64'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts just after the last
// grant and wraps; output is one-hot (or zero when nothing requests).
module rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] last,
  output logic [N-1:0]     grant
);

  logic [PTR_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int unsigned off = N; off >= 1; off--) begin
      idx = PTR_W'((32'(last) + off) % N);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l1_mem_bus_arbiter.sv
// Round-robin front end serialising N_PORTS L1 cache line requests onto a
// single memory port, with write snoop broadcast.
// Optional: define MEM_TIMEOUT_EN for a WAIT-state watchdog (resp_err).
module l1_mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned N_PORTS        = 2,
  parameter int unsigned ADDRESS_BITS   = 32,
  parameter int unsigned WORDSIZE       = DEFAULT_WORDSIZE,
  parameter int unsigned WORDSPERLINE   = DEFAULT_WORDSPERLINE,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [N_PORTS*ADDRESS_BITS-1:0]        cache2mem_addr,
  input  logic [N_PORTS*WORDSPERLINE*WORDSIZE-1:0] cache2mem_data,
  input  logic [N_PORTS-1:0]                     cache2mem_we,
  input  logic [N_PORTS-1:0]                     cache2mem_re,
  output logic [WORDSPERLINE*WORDSIZE-1:0]       mem2cache_data,
  output logic [N_PORTS-1:0]                     mem2cache_ready,
  output logic [N_PORTS-1:0]                     granted,
  output logic [ADDRESS_BITS-1:0]                snoop_addr,
  output logic                                   snoop_we,
  output logic [N_PORTS-1:0]                     snoop_src,
  output logic [ADDRESS_BITS-1:0]                mem_addr,
  output logic [WORDSPERLINE*WORDSIZE-1:0]       mem_wdata,
  output logic                                   mem_we,
  output logic                                   mem_re,
  input  logic [WORDSPERLINE*WORDSIZE-1:0]       mem_rdata,
  input  logic                                   mem_ready,
  output logic [N_PORTS-1:0]                     resp_err
);

  localparam int unsigned LINE_W   = WORDSPERLINE * WORDSIZE;
  localparam int unsigned PTR_W    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned OFF_BITS = $clog2(LINE_W / 8);
  localparam logic [PTR_W-1:0] LAST_RESET = PTR_W'(N_PORTS - 1);

  bus_state_t              state_q, state_d;
  logic [N_PORTS-1:0]      req, arb_grant, granted_q;
  logic [PTR_W-1:0]        last_q, gidx;
  logic [ADDRESS_BITS-1:0] addr_q, sel_addr;
  logic [LINE_W-1:0]       data_q, sel_data, resp_q;
  logic                    op_we_q, sel_we, active, timeout_hit;

  assign req = cache2mem_re | cache2mem_we;

  rr_arbiter #(.N(N_PORTS), .PTR_W(PTR_W)) u_arb (
    .req   (req),
    .last  (last_q),
    .grant (arb_grant)
  );

  // Select the winning port's request; write wins when both re and we are set.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_we   = 1'b0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (arb_grant[i]) begin
        sel_addr = cache2mem_addr[i*ADDRESS_BITS +: ADDRESS_BITS];
        sel_data = cache2mem_data[i*LINE_W +: LINE_W];
        sel_we   = cache2mem_we[i];
      end
    end
  end

  // Encode the current owner for the round-robin pointer.
  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (granted_q[i]) gidx = PTR_W'(i);
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q;
  logic             timed_out_q;

  assign timeout_hit = (state_q == WAIT) && !mem_ready &&
                       (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts WAIT cycles; cleared while idle so each grant starts fresh.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt_q  <= '0;
      timed_out_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          wait_cnt_q  <= '0;
          timed_out_q <= 1'b0;
        end
        WAIT: begin
          if (timeout_hit)     timed_out_q <= 1'b1;
          else if (!mem_ready) wait_cnt_q  <= wait_cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign resp_err = (state_q == DONE && timed_out_q) ? granted_q : '0;
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES != 0);
  assign timeout_hit    = 1'b0;
  assign resp_err       = '0;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|arb_grant) state_d = REQ;
      REQ:     state_d = mem_ready ? DONE : WAIT;
      WAIT:    if (mem_ready || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register plus request latch, response capture and RR pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      granted_q <= '0;
      last_q    <= LAST_RESET;
      addr_q    <= '0;
      data_q    <= '0;
      op_we_q   <= 1'b0;
      resp_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (|arb_grant) begin
            granted_q <= arb_grant;
            addr_q    <= sel_addr;
            data_q    <= sel_data;
            op_we_q   <= sel_we;
          end
        end
        REQ, WAIT: begin
          if (mem_ready)        resp_q <= op_we_q ? data_q : mem_rdata;
          else if (timeout_hit) resp_q <= '0;
        end
        DONE: begin
          granted_q <= '0;
          last_q    <= gidx;
        end
        default: ;
      endcase
    end
  end

  assign active          = (state_q == REQ) || (state_q == WAIT);
  assign granted         = granted_q;
  assign mem_addr        = active ? addr_q : '0;
  assign mem_wdata       = active ? data_q : '0;
  assign mem_we          = active && op_we_q;
  assign mem_re          = active && !op_we_q;
  assign snoop_we        = (state_q == REQ) && op_we_q;
  assign snoop_addr      = snoop_we ? ADDRESS_BITS'(line_align(64'(addr_q), OFF_BITS)) : '0;
  assign snoop_src       = snoop_we ? granted_q : '0;
  assign mem2cache_ready = (state_q == DONE) ? granted_q : '0;
  assign mem2cache_data  = (state_q == DONE) ? resp_q : '0;

endmodule
